// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the 16-bit pipeline: the memory-access FSM state
// encoding, the move-op field width, the machine word width and the default
// data-memory timeout.
package cpu_pkg;

    localparam int WORD_W          = 16;
    localparam int MOVOP_W         = 4;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory-access stage of the 16-bit pipeline. It takes one instruction per
// cycle from EX and performs at most one load or store over a req/ack
// data-memory port. While an access is outstanding, upstream is stalled.
// Results go to the MEM/WB buffer as a one-cycle out_valid pulse.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid                 EX presents an instruction
//   MemRead_in/MemWrite_in   load / store request
//   MemToReg_in/RegWrite_in  writeback controls (passed through)
//   ALU_Result_in            ALU result, also the memory word address
//   WriteData_in             store data
//   movOP_in                 move-op code (passed through)
//   stall                    upstream must hold (high while in ACCESS)
//   dmem_req/we/addr/wdata   data-memory request, held stable during access
//   dmem_ack/rdata           access complete / read data
//   out_valid                one-cycle result pulse
//   MemToReg_out/RegWrite_out  writeback controls, 0 when out_valid=0
//   ALU_Result_out/ReadData_out/movOP_out  result fields, held between results
//   err                      one-cycle pulse on timeout or illegal op
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W  = WORD_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               MemRead_in,
    input  logic               MemWrite_in,
    input  logic               MemToReg_in,
    input  logic               RegWrite_in,
    input  logic [DATA_W-1:0]  ALU_Result_in,
    input  logic [DATA_W-1:0]  WriteData_in,
    input  logic [MOVOP_W-1:0] movOP_in,
    output logic               stall,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               out_valid,
    output logic               MemToReg_out,
    output logic               RegWrite_out,
    output logic [DATA_W-1:0]  ALU_Result_out,
    output logic [DATA_W-1:0]  ReadData_out,
    output logic [MOVOP_W-1:0] movOP_out,
    output logic               err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t         state;
    logic [CNT_W-1:0]   wait_cnt;

    // Instruction held while its memory access is outstanding
    logic               is_load_p0;
    logic               mem_to_reg_p0;
    logic               reg_write_p0;
    logic [DATA_W-1:0]  alu_result_p0;
    logic [MOVOP_W-1:0] mov_op_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            stall          <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            out_valid      <= 1'b0;
            err            <= 1'b0;
            MemToReg_out   <= 1'b0;
            RegWrite_out   <= 1'b0;
            ALU_Result_out <= '0;
            ReadData_out   <= '0;
            movOP_out      <= '0;
            is_load_p0     <= 1'b0;
            mem_to_reg_p0  <= 1'b0;
            reg_write_p0   <= 1'b0;
            alu_result_p0  <= '0;
            mov_op_p0      <= '0;
        end else begin
            // Pulses and writeback controls default low; only a result sets them.
            out_valid    <= 1'b0;
            err          <= 1'b0;
            MemToReg_out <= 1'b0;
            RegWrite_out <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (MemRead_in && MemWrite_in) begin
                            // Illegal: report without touching memory or writing back.
                            out_valid      <= 1'b1;
                            err            <= 1'b1;
                            ALU_Result_out <= ALU_Result_in;
                            ReadData_out   <= '0;
                            movOP_out      <= movOP_in;
                        end else if (MemRead_in || MemWrite_in) begin
                            is_load_p0    <= MemRead_in;
                            mem_to_reg_p0 <= MemToReg_in;
                            reg_write_p0  <= RegWrite_in;
                            alu_result_p0 <= ALU_Result_in;
                            mov_op_p0     <= movOP_in;
                            dmem_req      <= 1'b1;
                            dmem_we       <= MemWrite_in;
                            dmem_addr     <= ALU_Result_in;
                            dmem_wdata    <= WriteData_in;
                            wait_cnt      <= '0;
                            stall         <= 1'b1;
                            state         <= ACCESS;
                        end else begin
                            out_valid      <= 1'b1;
                            MemToReg_out   <= MemToReg_in;
                            RegWrite_out   <= RegWrite_in;
                            ALU_Result_out <= ALU_Result_in;
                            ReadData_out   <= '0;
                            movOP_out      <= movOP_in;
                        end
                    end
                end

                ACCESS: begin
                    // Request lines stay as issued until the access retires.
                    if (dmem_ack) begin
                        dmem_req       <= 1'b0;
                        dmem_we        <= 1'b0;
                        stall          <= 1'b0;
                        state          <= IDLE;
                        out_valid      <= 1'b1;
                        MemToReg_out   <= mem_to_reg_p0;
                        RegWrite_out   <= reg_write_p0;
                        ALU_Result_out <= alu_result_p0;
                        ReadData_out   <= is_load_p0 ? dmem_rdata : '0;
                        movOP_out      <= mov_op_p0;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Timeout: retire the instruction as a failed, non-writing result.
                        dmem_req       <= 1'b0;
                        dmem_we        <= 1'b0;
                        stall          <= 1'b0;
                        state          <= IDLE;
                        out_valid      <= 1'b1;
                        err            <= 1'b1;
                        ALU_Result_out <= alu_result_p0;
                        ReadData_out   <= '0;
                        movOP_out      <= mov_op_p0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
